// File: rtl/display_pkg.sv
// display_pkg: shared seven-segment display constants, digit index type and anode lookup
package display_pkg;
    localparam int DEFAULT_REFRESH_DIV  = 100000;
    localparam int DEFAULT_BLANK_CYCLES = 16;
    typedef logic [1:0] digit_idx_t;
    localparam logic [3:0] ANODE_DIG0 = 4'b1110;
    localparam logic [3:0] ANODE_DIG1 = 4'b1101;
    localparam logic [3:0] ANODE_DIG2 = 4'b1011;
    localparam logic [3:0] ANODE_DIG3 = 4'b0111;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        return idx == 2'd0 ? ANODE_DIG0 :
               idx == 2'd1 ? ANODE_DIG1 :
               idx == 2'd2 ? ANODE_DIG2 : ANODE_DIG3;
    endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: counts 0..REFRESH_DIV-1 while enabled and flags the last count as a tick
// Ports: clk - system clock; rst_n - async active-low reset; en - count enable (low clears the count);
//        tick - high (combinational) in the cycle the count equals REFRESH_DIV-1
module refresh_prescaler #(
    parameter int REFRESH_DIV = display_pkg::DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    logic [CW-1:0] r_cnt;
    assign tick = en && r_cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (!en || tick) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/anode_scanner.sv
// anode_scanner: four-digit anode multiplexer showing A, B, A+B and A-B with frame-aligned operand updates
// Ports: clk, rst_n (async active-low); en - scan enable; load, a_in, b_in - operand capture request;
//        A, B, AplusB, AminusB - registered displayed values; anode - active-low digit select;
//        digit_idx - current slot; frame_done - one-cycle pulse after each 3->0 wrap.
// Build option: define ANODE_BLANK_EN to hold anode off for BLANK_CYCLES at the start of each slot.
module anode_scanner import display_pkg::*; #(
    parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] AplusB,
    output logic [3:0] AminusB,
    output logic [3:0] anode,
    output logic [1:0] digit_idx,
    output logic       frame_done
);
    if (REFRESH_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
        $error("anode_scanner: REFRESH_DIV must be >= 2 and 1 <= BLANK_CYCLES < REFRESH_DIV");
    end
    logic       w_tick;
    logic       w_wrap;
    logic       w_apply;
    logic       w_blank;
    logic [3:0] w_a;
    logic [3:0] w_b;
    digit_idx_t w_idx_nxt;
    digit_idx_t r_idx;
    logic       r_pend;
    logic [3:0] r_pa;
    logic [3:0] r_pb;
    refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (w_tick)
    );
    assign w_wrap    = w_tick && r_idx == 2'd3;
    assign w_idx_nxt = en ? r_idx + digit_idx_t'(w_tick) : 2'd0;
    // A concurrent load bypasses the pending buffer so it lands at the same wrap
    assign w_a       = load ? a_in : r_pa;
    assign w_b       = load ? b_in : r_pb;
    assign w_apply   = (!en || w_wrap) && (r_pend || load);
    assign digit_idx = r_idx;
`ifdef ANODE_BLANK_EN
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    logic [BW-1:0] r_bcnt;
    // The tick edge itself is the first blank cycle; r_bcnt covers the remaining ones
    assign w_blank = w_tick || r_bcnt != '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bcnt <= '0;
        else
            r_bcnt <= !en ? '0 : w_tick ? BW'(BLANK_CYCLES - 1) : (r_bcnt != '0) ? r_bcnt - 1'b1 : r_bcnt;
    end
`else
    assign w_blank = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A          <= '0;
            B          <= '0;
            AplusB     <= '0;
            AminusB    <= '0;
            anode      <= ANODE_OFF;
            r_idx      <= '0;
            frame_done <= 1'b0;
            r_pend     <= 1'b0;
            r_pa       <= '0;
            r_pb       <= '0;
        end else begin
            r_idx      <= w_idx_nxt;
            anode      <= (en && !w_blank) ? anode_for(w_idx_nxt) : ANODE_OFF;
            frame_done <= w_wrap;
            if (w_apply) begin
                A       <= w_a;
                B       <= w_b;
                AplusB  <= w_a + w_b;
                AminusB <= w_a - w_b;
                r_pend  <= 1'b0;
            end else if (load) begin
                r_pa   <= a_in;
                r_pb   <= b_in;
                r_pend <= 1'b1;
            end
        end
    end
endmodule
